// File: rtl/m1_pkg.sv
// Shared definitions for the YUV->RGB stage and the RGB SRAM pixel reader.
package m1_pkg;

    localparam logic [17:0] RGB_BASE = 18'd146944;
    localparam int          IMG_W    = 320;
    localparam int          IMG_H    = 240;

    typedef enum logic [1:0] {
        S_RD_IDLE,
        S_RD_FETCH,
        S_RD_DRAIN,
        S_RD_DONE
    } rd_state_e;

    typedef enum logic [1:0] {
        PH_A,
        PH_B,
        PH_C
    } rd_phase_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock FIFO with show-ahead read: rdata is the head entry whenever !empty.
module sync_word_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rgb_sram_pixel_reader.sv
// Streams the packed RGB frame out of SRAM as one pixel per valid/ready transfer.
// Words: w0={R0,G0}, w1={B0,R1}, w2={G1,B1}.
module rgb_sram_pixel_reader
    import m1_pkg::*;
#(
    parameter logic [17:0] RGB_BASE     = m1_pkg::RGB_BASE,
    parameter logic [16:0] NUM_WORDS    = 17'd115200,
    parameter logic [16:0] NUM_PIXELS   = 17'd76800,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          SRAM_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic [7:0]  pixel_R,
    output logic [7:0]  pixel_G,
    output logic [7:0]  pixel_B,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e               state, state_nxt;
    rd_phase_e               phase;
    logic [16:0]             word_addr, pix_cnt;
    logic [SRAM_LATENCY-1:0] inflight;
    logic [15:0]             rd_q, fifo_rdata;
    logic                    rd_vld;
    logic                    fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0]           fifo_count;
    logic [7:0]              used, r0, g0, r1;
    logic                    issue, start, accept, last_accept, out_free;

    assign SRAM_we_n   = 1'b1;
    assign busy        = (state != S_RD_IDLE);
    assign frame_done  = (state == S_RD_DONE);
    assign accept      = pixel_valid && pixel_ready;
    assign last_accept = accept && (pix_cnt == NUM_PIXELS - 1'b1);
    assign out_free    = !pixel_valid || pixel_ready;
    assign fifo_pop    = !fifo_empty && out_free;

    // Credits: FIFO occupancy plus every word still travelling back from SRAM.
    always_comb begin
        used = 8'(fifo_count) + 8'(rd_vld);
        for (int i = 0; i < SRAM_LATENCY; i++) used = used + 8'(inflight[i]);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= S_RD_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        start     = 1'b0;
        unique case (state)
            S_RD_IDLE: if (Enable) begin
                state_nxt = S_RD_FETCH;
                start     = 1'b1;
            end
            S_RD_FETCH: if (used < 8'(FIFO_DEPTH)) begin
                issue = 1'b1;
                if (word_addr == NUM_WORDS - 1'b1) state_nxt = S_RD_DRAIN;
            end
            S_RD_DRAIN: if (last_accept) state_nxt = S_RD_DONE;
            S_RD_DONE:  state_nxt = S_RD_IDLE;
            default:    state_nxt = S_RD_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            SRAM_address <= RGB_BASE;
            word_addr    <= '0;
            pix_cnt      <= '0;
            inflight     <= '0;
            rd_q         <= '0;
            rd_vld       <= 1'b0;
        end else begin
            inflight <= (inflight << 1) | SRAM_LATENCY'(issue);
            rd_vld   <= inflight[SRAM_LATENCY-1];
            if (inflight[SRAM_LATENCY-1]) rd_q <= SRAM_read_data;
            if (start) begin
                word_addr <= '0;
                pix_cnt   <= '0;
            end
            if (issue) begin
                SRAM_address <= RGB_BASE + {1'b0, word_addr};
                word_addr    <= word_addr + 1'b1;
            end
            if (accept) pix_cnt <= pix_cnt + 1'b1;
        end
    end

    sync_word_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .Clock  (Clock),
        .Resetn (Resetn),
        .push   (rd_vld),
        .pop    (fifo_pop),
        .wdata  (rd_q),
        .rdata  (fifo_rdata),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    a_no_overflow: assert property (@(posedge Clock) disable iff (!Resetn) !(rd_vld && fifo_full));

    // Unpacker: phase A only stages R0/G0, phases B and C each produce a pixel.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            phase       <= PH_A;
            r0          <= '0;
            g0          <= '0;
            r1          <= '0;
            pixel_R     <= '0;
            pixel_G     <= '0;
            pixel_B     <= '0;
            pixel_valid <= 1'b0;
        end else begin
            if (fifo_pop) begin
                unique case (phase)
                    PH_A: begin
                        r0    <= fifo_rdata[15:8];
                        g0    <= fifo_rdata[7:0];
                        phase <= PH_B;
                    end
                    PH_B: begin
                        pixel_R <= r0;
                        pixel_G <= g0;
                        pixel_B <= fifo_rdata[15:8];
                        r1      <= fifo_rdata[7:0];
                        phase   <= PH_C;
                    end
                    default: begin
                        pixel_R <= r1;
                        pixel_G <= fifo_rdata[15:8];
                        pixel_B <= fifo_rdata[7:0];
                        phase   <= PH_A;
                    end
                endcase
            end
            if (fifo_pop && phase != PH_A) pixel_valid <= 1'b1;
            else if (accept)               pixel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rgb_sram_pixel_reader.sv
// Scoreboard bench for rgb_sram_pixel_reader on a shortened frame that still ends at address 262143.
module tb_rgb_sram_pixel_reader;

    localparam logic [16:0] T_WORDS  = 17'd768;
    localparam logic [16:0] T_PIXELS = 17'd512;
    localparam logic [17:0] T_BASE   = 18'd261376;   // 262144 - T_WORDS
    localparam logic [17:0] T_LAST   = 18'd262143;

    logic        Clock, Resetn, Enable, pixel_ready;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic        SRAM_we_n, pixel_valid, busy, frame_done;
    logic [7:0]  pixel_R, pixel_G, pixel_B;

    int          tests = 0, errs = 0;
    int          acc_cnt, done_cnt, addr_chg, bad_addr, fifo_max;
    logic        use_fixed = 1'b0, rnd_ready = 1'b0;
    logic        stall_prev = 1'b0, done_prev = 1'b0;
    logic [23:0] pix_prev;
    logic [17:0] prev_addr, a1;
    logic [23:0] q[$];

    rgb_sram_pixel_reader #(
        .RGB_BASE(T_BASE), .NUM_WORDS(T_WORDS), .NUM_PIXELS(T_PIXELS),
        .FIFO_DEPTH(8), .SRAM_LATENCY(2)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
        .SRAM_address(SRAM_address), .SRAM_read_data(SRAM_read_data), .SRAM_we_n(SRAM_we_n),
        .pixel_R(pixel_R), .pixel_G(pixel_G), .pixel_B(pixel_B),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .busy(busy), .frame_done(frame_done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [15:0] wf(input logic [17:0] a, input logic fx);
        if (fx && a == T_BASE)          return 16'h1122;
        if (fx && a == T_BASE + 18'd1)  return 16'h3344;
        if (fx && a == T_BASE + 18'd2)  return 16'h5566;
        return a[15:0];
    endfunction

    // SRAM: address registered once, data then valid before the following edge.
    always @(posedge Clock) a1 <= SRAM_address;
    assign SRAM_read_data = wf(a1, use_fixed);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fill();
        logic [15:0] w0, w1, w2;
        q.delete();
        for (int p = 0; p < int'(T_PIXELS) / 2; p++) begin
            w0 = wf(T_BASE + 18'(3 * p), use_fixed);
            w1 = wf(T_BASE + 18'(3 * p + 1), use_fixed);
            w2 = wf(T_BASE + 18'(3 * p + 2), use_fixed);
            q.push_back({w0, w1[15:8]});
            q.push_back({w1[7:0], w2});
        end
    endtask

    task automatic pulse_enable();
        Enable = 1'b1;
        @(posedge Clock); #1;
        Enable = 1'b0;
    endtask

    task automatic begin_frame();
        acc_cnt = 0; done_cnt = 0; addr_chg = 0; bad_addr = 0;
        fill();
        pulse_enable();
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 20000; i++) begin
            if (done_cnt != 0) break;
            @(posedge Clock); #1;
        end
        chk("frame_done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (5) @(posedge Clock);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("pixels_accepted", 32'(acc_cnt), 32'(T_PIXELS));
        chk("frame_done_count", 32'(done_cnt), 32'd1);
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("addr_steps", 32'(addr_chg), 32'(T_WORDS) - 32'd1);
        chk("addr_monotonic", 32'(bad_addr), 32'd0);
        chk("last_addr", 32'(SRAM_address), 32'(T_LAST));
    endtask

    initial begin
        pixel_ready = 1'b1;
        forever begin
            @(posedge Clock); #1;
            pixel_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability, frame_done/busy, address sequence.
    always @(negedge Clock) begin
        if (Resetn) begin
            if (stall_prev) begin
                chk("hold_valid", 32'(pixel_valid), 32'd1);
                chk("hold_pixel", 32'({pixel_R, pixel_G, pixel_B}), 32'(pix_prev));
            end
            if (pixel_valid && pixel_ready) begin
                if (q.size() == 0) chk("extra_pixel", 32'({pixel_R, pixel_G, pixel_B}), 32'hFFFF_FFFF);
                else               chk("pixel", 32'({pixel_R, pixel_G, pixel_B}), 32'(q.pop_front()));
                acc_cnt++;
            end
            stall_prev = pixel_valid && !pixel_ready;
            pix_prev   = {pixel_R, pixel_G, pixel_B};
            if (done_prev) chk("busy_falls", 32'(busy), 32'd0);
            if (frame_done) begin
                done_cnt++;
                chk("done_after_last", 32'(acc_cnt), 32'(T_PIXELS));
            end
            done_prev = frame_done;
            if (SRAM_address != prev_addr && SRAM_address != T_BASE) begin
                addr_chg++;
                if (32'(SRAM_address) != 32'(prev_addr) + 32'd1) bad_addr++;
            end
            if (32'(dut.u_fifo.count) > fifo_max) fifo_max = 32'(dut.u_fifo.count);
        end else begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end
        prev_addr = SRAM_address;
    end

    initial begin
        Resetn = 1'b0; Enable = 1'b0; fifo_max = 0;
        acc_cnt = 0; done_cnt = 0; addr_chg = 0; bad_addr = 0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("rst_addr", 32'(SRAM_address), 32'(T_BASE));
        chk("rst_valid", 32'(pixel_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_rgb", 32'({pixel_R, pixel_G, pixel_B}), 32'd0);
        Resetn = 1'b1;

        // Idle with Enable low: nothing moves.
        repeat (20) @(posedge Clock);
        #1;
        chk("idle_addr", 32'(SRAM_address), 32'(T_BASE));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(pixel_valid), 32'd0);

        // Latency and packing with fixed first words; Enable sampled at edge E.
        use_fixed = 1'b1;
        begin_frame();
        chk("busy_after_enable", 32'(busy), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge Clock); #1;
            chk($sformatf("latency_E+%0d", k), 32'(pixel_valid), 32'(k == 6));
        end
        chk("first_pixel", 32'({pixel_R, pixel_G, pixel_B}), 32'h112233);
        finish_frame();

        // Full frame, data = address[15:0].
        use_fixed = 1'b0;
        begin_frame();
        finish_frame();

        // Random backpressure.
        rnd_ready = 1'b1;
        fifo_max  = 0;
        begin_frame();
        finish_frame();
        chk("fifo_max_le_8", 32'(fifo_max <= 8), 32'd1);
        rnd_ready = 1'b0;

        // Reset mid-frame, then restart from the frame base.
        begin_frame();
        for (int i = 0; i < 5000; i++) begin
            if (acc_cnt >= 300) break;
            @(posedge Clock); #1;
        end
        chk("reached_pixel_300", 32'(acc_cnt >= 300), 32'd1);
        Resetn = 1'b0;
        q.delete();
        repeat (2) @(posedge Clock);
        #1;
        chk("midrst_addr", 32'(SRAM_address), 32'(T_BASE));
        chk("midrst_valid", 32'(pixel_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        Resetn = 1'b1;
        @(posedge Clock); #1;
        begin_frame();
        finish_frame();

        // Enable while busy is ignored.
        begin_frame();
        repeat (100) @(posedge Clock);
        #1;
        pulse_enable();
        finish_frame();
        repeat (20) @(posedge Clock);
        #1;
        chk("no_second_frame_busy", 32'(busy), 32'd0);
        chk("no_second_frame_done", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
